// File: rtl/latbank_wrctl_pkg.sv
// latbank_wrctl_pkg -- shared definitions for the latch-bank write controller.
//   state_t  : controller FSM states, encoded with the ST_* constants
//   PAR_W    : number of parity bits appended to D (0 or 1)
// Optional feature macro: LATBANK_WRCTL_PARITY_EN (adds an even-parity bit to D).
package latbank_wrctl_pkg;

  localparam logic [2:0] ST_IDLE    = 3'd0;
  localparam logic [2:0] ST_SETUP   = 3'd1;
  localparam logic [2:0] ST_OPEN    = 3'd2;
  localparam logic [2:0] ST_HOLD    = 3'd3;
  localparam logic [2:0] ST_PRESET  = 3'd4;
  localparam logic [2:0] ST_RECOVER = 3'd5;

  typedef enum logic [2:0] {
    S_IDLE    = ST_IDLE,
    S_SETUP   = ST_SETUP,
    S_OPEN    = ST_OPEN,
    S_HOLD    = ST_HOLD,
    S_PRESET  = ST_PRESET,
    S_RECOVER = ST_RECOVER
  } state_t;

`ifdef LATBANK_WRCTL_PARITY_EN
  localparam int PAR_W = 1;
`else
  localparam int PAR_W = 0;
`endif

endpackage

// File: rtl/latbank_wrctl_dec.sv
// latbank_wrctl_dec -- address to one-hot latch-enable decoder.
//   addr   : word address (may exceed WORDS-1)
//   en     : decode enable; all outputs 0 when low
//   onehot : one bit per latch word, at most one bit set
// An address >= WORDS matches no output bit, so out-of-range writes
// produce an all-zero enable vector.
module latbank_wrctl_dec #(
  parameter int WORDS = 8,
  parameter int AW    = $clog2(WORDS)
) (
  input  logic [AW-1:0]    addr,
  input  logic             en,
  output logic [WORDS-1:0] onehot
);

  always_comb begin
    onehot = '0;
    for (int i = 0; i < WORDS; i++) begin
      if (en && (int'(addr) == i)) onehot[i] = 1'b1;
    end
  end

endmodule

// File: rtl/gf180mcu_fd_sc_mcu9t5v0__latbank_wrctl.sv
// gf180mcu_fd_sc_mcu9t5v0__latbank_wrctl -- write controller for a bank of
// WORDS x WIDTH transparent latches sharing one D bus and one active-low set.
//   CLK        : clock, rising edge
//   RN         : synchronous active-low reset
//   REQ_VALID  : write request present
//   REQ_READY  : write request accepted this cycle (combinational)
//   REQ_ADDR   : target word
//   REQ_DATA   : write data
//   PRESET_REQ : request to set every latch bit to 1
//   D          : shared latch data bus (WIDTH+1 bits with parity)
//   E          : one-hot per-word latch enables
//   SETN       : shared active-low latch set
//   BUSY       : controller is not idle
// Optional feature macro: LATBANK_WRCTL_PARITY_EN (D gains an even-parity MSB).
//
// Handshake: a write transfers on a rising CLK edge where REQ_VALID and
// REQ_READY are both high. REQ_READY is high only in IDLE with no preset
// pending; the requester may hold REQ_VALID and its payload until then.
// A write runs SETUP (D driven) -> OPEN (E pulse) -> HOLD (D kept) so the
// latch sees one cycle of setup and hold around its enable pulse.
module gf180mcu_fd_sc_mcu9t5v0__latbank_wrctl
  import latbank_wrctl_pkg::*;
#(
  parameter int WORDS         = 8,
  parameter int WIDTH         = 8,
  parameter int PRESET_CYCLES = 2,
  localparam int AW           = $clog2(WORDS),
  localparam int DW           = WIDTH + PAR_W
) (
  input  logic             CLK,
  input  logic             RN,
  input  logic             REQ_VALID,
  output logic             REQ_READY,
  input  logic [AW-1:0]    REQ_ADDR,
  input  logic [WIDTH-1:0] REQ_DATA,
  input  logic             PRESET_REQ,
  output logic [DW-1:0]    D,
  output logic [WORDS-1:0] E,
  output logic             SETN,
  output logic             BUSY
);

  localparam int CW = (PRESET_CYCLES > 1) ? $clog2(PRESET_CYCLES) : 1;

  state_t           state_q, state_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [AW-1:0]    addr_q;
  logic [DW-1:0]    d_q, d_nxt;
  logic [WORDS-1:0] e_q, dec_onehot;
  logic             setn_q, busy_q;
  logic             load;

  assign REQ_READY = (state_q == S_IDLE) && !PRESET_REQ;
  assign load      = REQ_VALID && REQ_READY;

`ifdef LATBANK_WRCTL_PARITY_EN
  assign d_nxt = {^REQ_DATA, REQ_DATA};
`else
  assign d_nxt = REQ_DATA;
`endif

  // Decoding from state_d lets E be a plain register that is high
  // exactly while the FSM sits in OPEN.
  latbank_wrctl_dec #(.WORDS(WORDS), .AW(AW)) u_dec (
    .addr   (addr_q),
    .en     (state_d == S_OPEN),
    .onehot (dec_onehot)
  );

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      S_IDLE: begin
        if (PRESET_REQ) begin
          state_d = S_PRESET;
          cnt_d   = '0;
        end else if (REQ_VALID) begin
          state_d = S_SETUP;
        end
      end
      S_SETUP:   state_d = S_OPEN;
      S_OPEN:    state_d = S_HOLD;
      S_HOLD:    state_d = S_IDLE;
      S_PRESET: begin
        if (cnt_q == CW'(PRESET_CYCLES - 1)) state_d = S_RECOVER;
        else                                  cnt_d   = cnt_q + 1'b1;
      end
      S_RECOVER: state_d = S_IDLE;
      default:   state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (!RN) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      addr_q  <= '0;
      d_q     <= '0;
      e_q     <= '0;
      setn_q  <= 1'b1;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      if (load) begin
        addr_q <= REQ_ADDR;
        d_q    <= d_nxt;
      end
      e_q    <= dec_onehot;
      setn_q <= (state_d != S_PRESET);
      busy_q <= (state_d != S_IDLE);
    end
  end

  assign D    = d_q;
  assign E    = e_q;
  assign SETN = setn_q;
  assign BUSY = busy_q;

endmodule

// File: tb/tb_gf180mcu_fd_sc_mcu9t5v0__latbank_wrctl.sv
// tb_gf180mcu_fd_sc_mcu9t5v0__latbank_wrctl -- self-checking bench for the
// latch-bank write controller, instantiated with WORDS=6, WIDTH=8,
// PRESET_CYCLES=2. Also builds with LATBANK_WRCTL_PARITY_EN defined.
module tb_gf180mcu_fd_sc_mcu9t5v0__latbank_wrctl;
  import latbank_wrctl_pkg::*;

  localparam int WORDS = 6;
  localparam int DW    = 8 + PAR_W;

  // ---------------- clock / reset ----------------
  logic             CLK = 1'b0;
  logic             RN;
  logic             REQ_VALID;
  logic             REQ_READY;
  logic [2:0]       REQ_ADDR;
  logic [7:0]       REQ_DATA;
  logic             PRESET_REQ;
  logic [DW-1:0]    D;
  logic [WORDS-1:0] E;
  logic             SETN;
  logic             BUSY;

  always #5 CLK = ~CLK;

  gf180mcu_fd_sc_mcu9t5v0__latbank_wrctl #(
    .WORDS(WORDS), .WIDTH(8), .PRESET_CYCLES(2)
  ) dut (
    .CLK(CLK), .RN(RN), .REQ_VALID(REQ_VALID), .REQ_READY(REQ_READY),
    .REQ_ADDR(REQ_ADDR), .REQ_DATA(REQ_DATA), .PRESET_REQ(PRESET_REQ),
    .D(D), .E(E), .SETN(SETN), .BUSY(BUSY)
  );

  // ---------------- scoreboard ----------------
  int n_cmp = 0;
  int n_bad = 0;
  logic [WORDS+DW-1:0] exp_q[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  function automatic logic [DW-1:0] exp_d(input logic [7:0] data);
`ifdef LATBANK_WRCTL_PARITY_EN
    return {^data, data};
`else
    return data;
`endif
  endfunction

  // SETN low and an open enable must never coincide.
  always @(negedge CLK) begin
    if (RN === 1'b1) begin
      n_cmp++;
      if (!SETN && (|E)) begin
        n_bad++;
        $display("FAIL setn_e_overlap: SETN=%0b E=0x%0h", SETN, E);
      end
    end
  end

  // ---------------- driver tasks ----------------
  // Called at the negedge of the accept cycle (REQ_READY already high).
  task automatic follow(input logic [7:0] data, input logic [WORDS-1:0] exp_e);
    logic [WORDS+DW-1:0] exp;
    exp_q.push_back({exp_e, exp_d(data)});
    @(negedge CLK); REQ_VALID = 1'b0; #1;           // SETUP
    check("setup_d", 32'(D), 32'(exp_d(data)));
    check("setup_e", 32'(E), 0);
    check("setup_busy", 32'(BUSY), 1);
    @(negedge CLK); #1;                              // OPEN
    if (exp_q.size() == 0) begin
      check("sb_empty", 0, 1);
    end else begin
      exp = exp_q.pop_front();
      check("open_e", 32'(E), 32'(exp[WORDS+DW-1:DW]));
      check("open_d", 32'(D), 32'(exp[DW-1:0]));
    end
    check("open_busy", 32'(BUSY), 1);
    @(negedge CLK); #1;                              // HOLD
    check("hold_d", 32'(D), 32'(exp_d(data)));
    check("hold_e", 32'(E), 0);
    check("hold_busy", 32'(BUSY), 1);
    @(negedge CLK); #1;                              // IDLE again
    check("idle_busy", 32'(BUSY), 0);
    check("idle_ready", 32'(REQ_READY), 1);
    check("idle_e", 32'(E), 0);
  endtask

  task automatic write_check(input logic [2:0] addr, input logic [7:0] data,
                             input logic [WORDS-1:0] exp_e);
    int tries = 0;
    @(negedge CLK);
    REQ_VALID = 1'b1; REQ_ADDR = addr; REQ_DATA = data; #1;
    while (!REQ_READY && tries < 20) begin
      @(negedge CLK); #1; tries++;
    end
    if (!REQ_READY) begin
      check("accept_timeout", 0, 1);
      REQ_VALID = 1'b0;
    end else begin
      follow(data, exp_e);
    end
  endtask

  // ---------------- vectors ----------------
  typedef struct {
    logic [2:0]       addr;
    logic [7:0]       data;
    logic [WORDS-1:0] exp_e;
  } vec_t;
  vec_t vecs[6];

  initial begin
    logic [DW-1:0] d_before;
    int low, e_seen, busy_cyc, dchg, n_acc, first_acc, last_acc;
    bit done;

    vecs[0] = '{3'd3, 8'hA5, 6'h08};
    vecs[1] = '{3'd0, 8'h07, 6'h01};
    vecs[2] = '{3'd5, 8'h03, 6'h20};
    vecs[3] = '{3'd7, 8'hC3, 6'h00};   // out of range
    vecs[4] = '{3'd6, 8'hFF, 6'h00};   // out of range
    vecs[5] = '{3'd2, 8'h00, 6'h04};

    // Reset with a request pending: nothing may be accepted.
    RN = 1'b0; REQ_VALID = 1'b1; REQ_ADDR = 3'd3; REQ_DATA = 8'hFF; PRESET_REQ = 1'b0;
    repeat (2) @(posedge CLK);
    @(negedge CLK); #1;
    check("rst_e", 32'(E), 0);
    check("rst_setn", 32'(SETN), 1);
    check("rst_d", 32'(D), 0);
    check("rst_busy", 32'(BUSY), 0);
    RN = 1'b1; REQ_VALID = 1'b0;
    @(negedge CLK); #1;
    check("rst_no_accept", 32'(BUSY), 0);

    // Table-driven writes.
    for (int i = 0; i < 6; i++) write_check(vecs[i].addr, vecs[i].data, vecs[i].exp_e);

    // D retains the last written value while idle.
    write_check(3'd1, 8'h03, 6'h02);
    repeat (2) @(negedge CLK);
    #1 check("retain_d", 32'(D), 32'(exp_d(8'h03)));
`ifdef LATBANK_WRCTL_PARITY_EN
    check("par_03", 32'(D[8]), 0);
    write_check(3'd4, 8'h07, 6'h10);
    check("par_07", 32'(D[8]), 1);
`endif

    // Preset colliding with a write request: preset wins.
    @(negedge CLK);
    PRESET_REQ = 1'b1; REQ_VALID = 1'b1; REQ_ADDR = 3'd1; REQ_DATA = 8'h3C; #1;
    check("collide_ready", 32'(REQ_READY), 0);
    d_before = D; low = 0; e_seen = 0; busy_cyc = 0; dchg = 0; done = 1'b0;
    for (int i = 0; i < 12 && !done; i++) begin
      @(negedge CLK); #1;
      if (BUSY) begin
        busy_cyc++;
        PRESET_REQ = 1'b0;
        if (!SETN) low++;
        if (|E) e_seen++;
        if (D !== d_before) dchg++;
      end else if (busy_cyc > 0) begin
        done = 1'b1;
      end
    end
    check("preset_done", 32'(done), 1);
    check("preset_setn_low", low, 2);
    check("preset_busy_len", busy_cyc, 3);
    check("preset_e", e_seen, 0);
    check("preset_d_kept", dchg, 0);
    check("preset_then_ready", 32'(REQ_READY), 1);
    if (done && REQ_READY) follow(8'h3C, 6'h02);

    // Back-to-back writes: one accept every 4 cycles.
    @(negedge CLK);
    REQ_VALID = 1'b1; REQ_ADDR = 3'd4; REQ_DATA = 8'h11;
    n_acc = 0; first_acc = -1; last_acc = -1;
    for (int c = 0; c < 12; c++) begin
      #1;
      if (REQ_READY) begin
        if (first_acc < 0) first_acc = c;
        last_acc = c;
        n_acc++;
      end
      @(negedge CLK);
    end
    REQ_VALID = 1'b0;
    check("b2b_count", n_acc, 3);
    check("b2b_spacing", last_acc - first_acc, 8);
    for (int i = 0; i < 10 && BUSY; i++) @(negedge CLK);
    #1 check("b2b_drain", 32'(BUSY), 0);

    // Reset while OPEN aborts the write.
    @(negedge CLK);
    REQ_VALID = 1'b1; REQ_ADDR = 3'd2; REQ_DATA = 8'h5A; #1;
    check("mid_ready", 32'(REQ_READY), 1);
    @(negedge CLK); REQ_VALID = 1'b0;                // SETUP
    @(negedge CLK); #1;                              // OPEN
    check("mid_open_e", 32'(E), 32'h04);
    RN = 1'b0;
    @(negedge CLK); #1;
    check("mid_rst_e", 32'(E), 0);
    check("mid_rst_busy", 32'(BUSY), 0);
    check("mid_rst_setn", 32'(SETN), 1);
    check("mid_rst_d", 32'(D), 0);
    check("mid_rst_state", 32'(dut.state_q), 32'(ST_IDLE));
    RN = 1'b1;
    @(negedge CLK); #1;
    check("mid_stay_idle", 32'(BUSY), 0);

    check("sb_leftover", exp_q.size(), 0);

    // ---------------- report ----------------
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/gf180mcu_fd_sc_mcu9t5v0__latbank_wrctl.md
GF180MCU_FD_SC_MCU9T5V0__LATBANK_WRCTL -- requirements
Module: gf180mcu_fd_sc_mcu9t5v0__latbank_wrctl

Interface
REQ-001 The block SHALL have parameter WORDS, default 8, meaning the number of latch words driven (range 2..32).
REQ-002 The block SHALL have parameter WIDTH, default 8, meaning the data bits per word.
REQ-003 The block SHALL have parameter PRESET_CYCLES, default 2, meaning the SETN low pulse length in cycles (minimum 1).
REQ-004 The block SHALL have port CLK, input, width 1: the single clock, rising edge active.
REQ-005 The block SHALL have port RN, input, width 1: reset, synchronous and active-low.
REQ-006 The block SHALL have port REQ_VALID, input, width 1: a write request is present.
REQ-007 The block SHALL have port REQ_READY, output, width 1: a write request is accepted this cycle.
REQ-008 The block SHALL have port REQ_ADDR, input, width clog2(WORDS): the target word.
REQ-009 The block SHALL have port REQ_DATA, input, width WIDTH: the write data.
REQ-010 The block SHALL have port PRESET_REQ, input, width 1: request to set all latch bits to 1.
REQ-011 The block SHALL have port D, output, width WIDTH (WIDTH+1 with parity): data to all latch D pins.
REQ-012 The block SHALL have port E, output, width WORDS: one-hot per-word latch enables, active-high.
REQ-013 The block SHALL have port SETN, output, width 1: the shared active-low latch set.
REQ-014 The block SHALL have port BUSY, output, width 1: the FSM is not in IDLE.

Function
REQ-015 The FSM SHALL have states IDLE, SETUP, OPEN, HOLD, PRESET and RECOVER.
REQ-016 REQ_READY SHALL be combinational and equal (state==IDLE && !PRESET_REQ).
REQ-017 A handshake (REQ_VALID && REQ_READY) SHALL register address and data, then go IDLE->SETUP->OPEN->HOLD->IDLE, one cycle per state.
REQ-018 D SHALL take the registered data in SETUP and stay stable through OPEN and HOLD, giving one cycle of setup and one of hold around E.
REQ-019 E[addr] SHALL be 1 only in OPEN, and all other E bits SHALL be 0 at all times.
REQ-020 A request with REQ_ADDR >= WORDS SHALL be accepted and sequenced normally, with E held all-zero.
REQ-021 PRESET_REQ in IDLE SHALL go to PRESET with SETN=0 for exactly PRESET_CYCLES cycles, then RECOVER (SETN=1, 1 cycle), then IDLE.
REQ-022 When PRESET_REQ and REQ_VALID are both high in IDLE, preset SHALL win and the write SHALL NOT be accepted.
REQ-023 PRESET_REQ outside IDLE SHALL be ignored; the requester holds it until BUSY=0.
REQ-024 SETN=0 and any E bit = 1 SHALL never occur in the same cycle.
REQ-025 Back-to-back writes SHALL sustain one write per 4 cycles.
REQ-026 D SHALL retain its last value in IDLE, PRESET and RECOVER.

Reset
REQ-027 On a CLK edge with RN=0, the block SHALL set state to IDLE, E to 0, SETN to 1, D to 0 and BUSY to 0, aborting any write or preset in progress.
REQ-028 All outputs SHALL be registered except REQ_READY.

Configuration
REQ-029 With LATBANK_WRCTL_PARITY_EN defined, D SHALL be WIDTH+1 bits, with D[WIDTH] equal to the even parity of REQ_DATA, registered with the data; a preset drives all bits, including parity, to 1.
REQ-030 Without LATBANK_WRCTL_PARITY_EN, D SHALL be WIDTH bits and there SHALL be no parity logic.

Structure
REQ-031 The package latbank_wrctl_pkg SHALL hold the state enum and the state encoding constants.
REQ-032 The sub-module latbank_wrctl_dec SHALL implement the address-to-one-hot decoder with its out-of-range suppression.

Verification
REQ-033 Reset: RN=0 for 2 cycles with REQ_VALID=1 -> E=0, SETN=1, D=0, BUSY=0, no write accepted.
REQ-034 Single write: ADDR=3, DATA=0xA5 -> D=0xA5 from SETUP; E=0x08 for exactly 1 cycle one cycle later; D still 0xA5 the cycle after; READY again 4 cycles after accept.
REQ-035 Preset vs write collision: PRESET_REQ=1 and REQ_VALID=1 in IDLE -> READY=0, SETN low 2 cycles, E=0 throughout, write accepted after RECOVER.
REQ-036 Out-of-range request: WORDS=6, ADDR=7 -> handshake completes, BUSY high 3 cycles, E stays 0.
REQ-037 Mid-operation reset: RN=0 while in OPEN -> E=0 at the next edge and state IDLE.
REQ-038 Parity build: DATA=0x07 -> D[8]=1; DATA=0x03 -> D[8]=0.
